// File: rtl/alu_sequencer_if.sv
// Purpose: bundles the instruction, ALU, result and status signals of alu_sequencer.
// Latency: none; this is wiring only.
// Backpressure: instr_ready / result_ready carry the valid-ready handshakes.
interface alu_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [3:0]       instr_op;
    logic [WIDTH-1:0] instr_data;
    logic             alu_enable;
    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] alu_acc;
    logic [WIDTH-1:0] alu_operand;
    logic [WIDTH-1:0] alu_out;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_data;
    logic [WIDTH-1:0] acc;
    logic             busy;
    logic             err_div0;
    logic             err_illegal;

    // Environment side: instruction source, ALU, result consumer.
    modport master (
        output instr_valid, instr_op, instr_data, alu_out, result_ready,
        input  instr_ready, alu_enable, alu_cmd, alu_acc, alu_operand,
               result_valid, result_data, acc, busy, err_div0, err_illegal
    );

    // Sequencer side.
    modport slave (
        input  instr_valid, instr_op, instr_data, alu_out, result_ready,
        output instr_ready, alu_enable, alu_cmd, alu_acc, alu_operand,
               result_valid, result_data, acc, busy, err_div0, err_illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Purpose: accumulator instruction sequencer feeding an external ALU; owns acc.
// Latency: LOAD/CLEAR update acc at the accept edge; ALU ops write acc ALU_LATENCY+1 edges after accept.
// Backpressure: instr_ready only in IDLE; STORE holds result_valid/result_data until result_ready.
module alu_sequencer #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 1   // 1..15, sized to the 4-bit wait counter
) (
    input  logic            clock,
    input  logic            reset_n,
    alu_sequencer_if.slave  bus
);
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_DIV   = 4'h4;
    localparam logic [3:0] OP_INV   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_CLEAR = 4'h9;
    localparam logic [3:0] OP_STORE = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       alu_cmd_q, alu_cmd_d;
    logic [WIDTH-1:0] alu_acc_q, alu_acc_d;
    logic [WIDTH-1:0] alu_operand_q, alu_operand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             result_valid_q, result_valid_d;
    logic [WIDTH-1:0] result_data_q, result_data_d;
    logic             err_div0_q, err_div0_d;
    logic             err_illegal_q, err_illegal_d;

    // Next-state and datapath decode; everything holds unless a branch changes it.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        alu_cmd_d      = alu_cmd_q;
        alu_acc_d      = alu_acc_q;
        alu_operand_d  = alu_operand_q;
        cnt_d          = cnt_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        err_div0_d     = err_div0_q;
        err_illegal_d  = err_illegal_q;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    case (bus.instr_op)
                        OP_NOP: ;
                        OP_ADD, OP_SUB, OP_MUL, OP_INV: begin
                            alu_cmd_d     = bus.instr_op;
                            alu_acc_d     = acc_q;
                            alu_operand_d = bus.instr_data;
                            state_d       = S_ISSUE;
                        end
                        OP_DIV: begin
                            // A zero divisor is rejected here so the ALU never sees it.
                            if (bus.instr_data == '0) begin
                                err_div0_d = 1'b1;
                            end else begin
                                alu_cmd_d     = bus.instr_op;
                                alu_acc_d     = acc_q;
                                alu_operand_d = bus.instr_data;
                                state_d       = S_ISSUE;
                            end
                        end
                        OP_LOAD:  acc_d = bus.instr_data;
                        OP_CLEAR: acc_d = '0;
                        OP_STORE: begin
                            result_data_d  = acc_q;
                            result_valid_d = 1'b1;
                            state_d        = S_OUTPUT;
                        end
                        default:  err_illegal_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'(ALU_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Last wait edge: ALU output is valid now, commit it.
                if (cnt_q == 4'd1) begin
                    acc_d   = bus.alu_out;
                    state_d = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (bus.result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight op without writeback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            alu_cmd_q      <= '0;
            alu_acc_q      <= '0;
            alu_operand_q  <= '0;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            err_div0_q     <= 1'b0;
            err_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            alu_cmd_q      <= alu_cmd_d;
            alu_acc_q      <= alu_acc_d;
            alu_operand_q  <= alu_operand_d;
            cnt_q          <= cnt_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            err_div0_q     <= err_div0_d;
            err_illegal_q  <= err_illegal_d;
        end
    end

    // Enable is decoded from state so reset clears it asynchronously.
    assign bus.instr_ready  = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.alu_enable   = (state_q == S_ISSUE);
    assign bus.alu_cmd      = alu_cmd_q;
    assign bus.alu_acc      = alu_acc_q;
    assign bus.alu_operand  = alu_operand_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_data_q;
    assign bus.acc          = acc_q;
    assign bus.err_div0     = err_div0_q;
    assign bus.err_illegal  = err_illegal_q;
endmodule
